// File: rtl/stream_mux_arb.sv
// Purpose : steer one of NUM_IN valid/ready streams (explicit select or round-robin) into one output register.
// Latency : one cycle; a word accepted at edge N is on out_data after edge N.
// Backpres: in_ready is only raised when the output stage is empty or draining; a stalled stage freezes its word.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_data/in_valid      NUM_IN packed producer words (channel i at [i*WIDTH +: WIDTH]) and their valids
//   in_ready              one-hot (or zero) acceptance back to the producers
//   sel                   explicit channel select, used only when MODE = 0
//   out_data/out_valid    registered word and its valid towards the consumer
//   out_ready             consumer accepts out_data this cycle
//   out_src               channel index the held word came from
module stream_mux_arb #(
   parameter int WIDTH  = 16,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = $clog2(NUM_IN),
   parameter int MODE   = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [NUM_IN-1:0]       in_valid,
   output logic [NUM_IN-1:0]       in_ready,
   input  logic [SEL_W-1:0]        sel,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [SEL_W-1:0]        out_src
);

   logic             space;
   logic             grantVld;
   logic [SEL_W-1:0] grantIdx;
   logic [WIDTH-1:0] grantDat;
   logic             xfer;
   logic [SEL_W-1:0] rrPtr;   // last channel granted; search starts one past it
   logic [SEL_W-1:0] candIdx;
   int               cand;

   assign space = !out_valid || out_ready;
   assign xfer  = grantVld && space;

   always_comb begin
      grantVld = 1'b0;
      grantIdx = '0;
      grantDat = '0;
      cand     = 0;
      candIdx  = '0;
      in_ready = '0;
      if (MODE == 0) begin
         // A select value past the last channel matches nothing, so no grant.
         for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i) && in_valid[i]) begin
               grantVld = 1'b1;
               grantIdx = SEL_W'(i);
            end
         end
      end else begin
         // Walk from the lowest priority position back to rrPtr+1; the last
         // valid hit is the nearest one after rrPtr, i.e. the winner.
         for (int k = NUM_IN; k >= 1; k--) begin
            cand = int'(rrPtr) + k;
            if (cand >= NUM_IN) begin
               cand = cand - NUM_IN;
            end
            candIdx = SEL_W'(cand);
            if (in_valid[candIdx]) begin
               grantVld = 1'b1;
               grantIdx = candIdx;
            end
         end
      end
      for (int i = 0; i < NUM_IN; i++) begin
         if (grantVld && grantIdx == SEL_W'(i)) begin
            grantDat    = in_data[i*WIDTH +: WIDTH];
            in_ready[i] = space;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
         rrPtr     <= SEL_W'(NUM_IN - 1);
      end else if (xfer) begin
         // Covers both load-into-empty and drain-and-reload without a bubble.
         out_valid <= 1'b1;
         out_data  <= grantDat;
         out_src   <= grantIdx;
         if (MODE != 0) begin
            rrPtr <= grantIdx;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Purpose : checks three stream_mux_arb instances (select/4ch, round-robin/4ch, select/3ch) sharing one stimulus.
// Latency : a reference model steps with the clock; outputs are compared on every falling edge.
// Backpres: out_ready is driven by directed sequences including multi-cycle stalls.
module tb_stream_mux_arb;

   logic        clk;
   logic        rst_n;
   logic [63:0] inDat;
   logic [3:0]  inVld;
   logic [1:0]  sel;
   logic        outReady;

   logic [3:0]  inRdy0, inRdy1;
   logic [2:0]  inRdy2;
   logic [15:0] outDat0, outDat1, outDat2;
   logic        outVld0, outVld1, outVld2;
   logic [1:0]  outSrc0, outSrc1, outSrc2;

   int total = 0;
   int bad   = 0;

   stream_mux_arb #(.WIDTH(16), .NUM_IN(4), .MODE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_data(inDat), .in_valid(inVld), .in_ready(inRdy0),
      .sel(sel), .out_data(outDat0), .out_valid(outVld0), .out_ready(outReady), .out_src(outSrc0));

   stream_mux_arb #(.WIDTH(16), .NUM_IN(4), .MODE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_data(inDat), .in_valid(inVld), .in_ready(inRdy1),
      .sel(sel), .out_data(outDat1), .out_valid(outVld1), .out_ready(outReady), .out_src(outSrc1));

   stream_mux_arb #(.WIDTH(16), .NUM_IN(3), .MODE(0)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_data(inDat[47:0]), .in_valid(inVld[2:0]), .in_ready(inRdy2),
      .sel(sel), .out_data(outDat2), .out_valid(outVld2), .out_ready(outReady), .out_src(outSrc2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int          modeOf[3] = '{0, 1, 0};
   int          nOf[3]    = '{4, 4, 3};
   int          mVld[3]   = '{0, 0, 0};
   int          mSrc[3]   = '{0, 0, 0};
   int          mRr[3]    = '{3, 3, 2};
   logic [15:0] mDat[3]   = '{16'h0, 16'h0, 16'h0};

   // Which channel the rules say wins this cycle, or -1.
   function automatic int pick(input int mode, input int n, input int s, input logic [3:0] v, input int rr);
      if (mode == 0) begin
         if (s < n && v[s]) return s;
         return -1;
      end
      for (int k = 1; k <= n; k++) begin
         if (v[(rr + k) % n]) return (rr + k) % n;
      end
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 3; k++) begin
         if (!rst_n) begin
            mVld[k] = 0;
            mDat[k] = 16'h0;
            mSrc[k] = 0;
            mRr[k]  = nOf[k] - 1;
         end else begin
            int g;
            g = pick(modeOf[k], nOf[k], int'(sel), inVld, mRr[k]);
            if (g >= 0 && (mVld[k] == 0 || outReady)) begin
               mVld[k] = 1;
               mDat[k] = inDat[g*16 +: 16];
               mSrc[k] = g;
               if (modeOf[k] == 1) mRr[k] = g;
            end else if (outReady) begin
               mVld[k] = 0;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      logic [3:0]  aRdy[3];
      logic [15:0] aDat[3];
      logic        aVld[3];
      logic [1:0]  aSrc[3];
      aRdy[0] = inRdy0;  aRdy[1] = inRdy1;  aRdy[2] = {1'b0, inRdy2};
      aDat[0] = outDat0; aDat[1] = outDat1; aDat[2] = outDat2;
      aVld[0] = outVld0; aVld[1] = outVld1; aVld[2] = outVld2;
      aSrc[0] = outSrc0; aSrc[1] = outSrc1; aSrc[2] = outSrc2;
      for (int k = 0; k < 3; k++) begin
         int g;
         logic [3:0] eRdy;
         g = pick(modeOf[k], nOf[k], int'(sel), inVld, mRr[k]);
         eRdy = 4'b0;
         if (g >= 0 && (mVld[k] == 0 || outReady)) eRdy[g] = 1'b1;
         check($sformatf("model_vld%0d", k), 32'(aVld[k]), 32'(mVld[k] != 0));
         check($sformatf("model_dat%0d", k), 32'(aDat[k]), 32'(mDat[k]));
         check($sformatf("model_src%0d", k), 32'(aSrc[k]), 32'(mSrc[k]));
         check($sformatf("model_rdy%0d", k), 32'(aRdy[k]), 32'(eRdy));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic doReset();
      inVld = 4'b0;
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
   endtask

   int rdyPat[5] = '{1, 0, 1, 0, 1};
   int srcPat[5] = '{1, 1, 3, 3, 1};

   initial begin
      rst_n    = 1'b0;
      inDat    = 64'h0;
      inVld    = 4'b0;
      sel      = 2'd0;
      outReady = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
      check("rst_vld", 32'(outVld0), 32'd0);
      check("rst_dat", 32'(outDat0), 32'd0);
      check("rst_src", 32'(outSrc0), 32'd0);

      // Explicit select of channel 2.
      sel = 2'd2; inVld = 4'b0100; inDat[47:32] = 16'hBEEF; outReady = 1'b1;
      #1;
      check("t1_rdy", 32'(inRdy0), 32'h4);
      cyc();
      check("t1_dat", 32'(outDat0), 32'hBEEF);
      check("t1_src", 32'(outSrc0), 32'd2);
      check("t1_vld", 32'(outVld0), 32'd1);

      // Load 1234, then stall three cycles while inputs churn.
      sel = 2'd0; inVld = 4'b0001; inDat[15:0] = 16'h1234;
      cyc();
      outReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sel = 2'(i + 1); inVld = 4'b1111; inDat = {16'h7777, 16'h6666, 16'h5555, 16'(16'h4440 + i)};
         #1;
         check("t2_rdy_stall", 32'(inRdy0), 32'd0);
         cyc();
         check("t2_dat_hold", 32'(outDat0), 32'h1234);
      end
      outReady = 1'b1; inVld = 4'b0;
      #1;
      check("t2_last_vld", 32'(outVld0), 32'd1);
      check("t2_last_dat", 32'(outDat0), 32'h1234);
      cyc();
      check("t2_drained", 32'(outVld0), 32'd0);

      // Round-robin over four always-valid channels.
      doReset();
      inDat = {16'hA003, 16'hA002, 16'hA001, 16'hA000}; inVld = 4'b1111; outReady = 1'b1;
      for (int j = 0; j < 6; j++) begin
         cyc();
         check("t3_src", 32'(outSrc1), 32'(j % 4));
         check("t3_dat", 32'(outDat1), 32'(16'hA000 + (j % 4)));
         check("t3_vld", 32'(outVld1), 32'd1);
      end

      // Round-robin over channels 1 and 3 with a toggling consumer.
      doReset();
      inVld = 4'b1010;
      for (int j = 0; j < 5; j++) begin
         outReady = rdyPat[j][0];
         cyc();
         check("t4_src", 32'(outSrc1), 32'(srcPat[j]));
         check("t4_vld", 32'(outVld1), 32'd1);
      end

      // Out-of-range select on the 3-channel instance.
      sel = 2'd3; inVld = 4'b1111; outReady = 1'b1;
      #1;
      check("t5_rdy", 32'(inRdy2), 32'd0);
      cyc();
      cyc();
      check("t5_vld", 32'(outVld2), 32'd0);

      // Asynchronous reset with a word held.
      sel = 2'd0; inVld = 4'b1111; outReady = 1'b0;
      cyc();
      check("t6_pre_vld", 32'(outVld0), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("t6_async_vld0", 32'(outVld0), 32'd0);
      check("t6_async_dat0", 32'(outDat0), 32'd0);
      check("t6_async_vld1", 32'(outVld1), 32'd0);
      cyc();
      rst_n = 1'b1; outReady = 1'b1;
      cyc();
      check("t6_first_rr", 32'(outSrc1), 32'd0);
      check("t6_first_vld", 32'(outVld1), 32'd1);

      inVld = 4'b0;
      cyc();
      cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
